// File: rtl/vip_field_arbiter_16b.sv
// Two-input Avalon-ST frame arbiter: grants a whole frame (control packets plus one
// video packet) per arbitration, round-robin, and decodes control packets into status.
// State table:  IDLE | no grant, drain stray beats, arbitrate sop requests
//               PASS | stream from in[grant] until the video packet eop
module vip_field_arbiter_16b #(
  parameter int DATA_W         = 16,
  parameter bit FIRST_PRIORITY = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic              in0_sop,
  input  logic              in0_eop,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic              in1_sop,
  input  logic              in1_eop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              grant,
  output logic              busy,
  output logic [15:0]       cur_width,
  output logic [15:0]       cur_height,
  output logic [3:0]        cur_interlace,
  output logic              ctrl_update,
  output logic              err_stray,
  output logic              err_ctrl
);

  typedef enum logic {S_IDLE, S_PASS} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d, rr_next_q, rr_next_d;
  logic [2:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  pkt_type_q, pkt_type_d;
  logic        in_pkt_q, in_pkt_d;
  logic [15:0] sh_width_q, sh_width_d, sh_height_q, sh_height_d;
  logic [15:0] cur_width_q, cur_width_d, cur_height_q, cur_height_d;
  logic [3:0]  cur_ilace_q, cur_ilace_d;
  logic        upd_q, upd_d, stray_q, stray_d, ctrl_err_q, ctrl_err_d;

  logic [DATA_W-1:0] sel_data;
  logic              sel_valid, sel_sop, sel_eop, req0, req1, xfer;
  logic [3:0]        eff_type;
  logic [2:0]        beat_idx;

  assign sel_data  = grant_q ? in1_data  : in0_data;
  assign sel_valid = grant_q ? in1_valid : in0_valid;
  assign sel_sop   = grant_q ? in1_sop   : in0_sop;
  assign sel_eop   = grant_q ? in1_eop   : in0_eop;
  assign req0      = in0_valid & in0_sop;
  assign req1      = in1_valid & in1_sop;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_next_d   = rr_next_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_type_d  = pkt_type_q;
    in_pkt_d    = in_pkt_q;
    sh_width_d  = sh_width_q;
    sh_height_d = sh_height_q;
    cur_width_d = cur_width_q;
    cur_height_d = cur_height_q;
    cur_ilace_d = cur_ilace_q;
    upd_d       = 1'b0;
    stray_d     = 1'b0;
    ctrl_err_d  = 1'b0;
    out_valid   = 1'b0;
    in0_ready   = 1'b0;
    in1_ready   = 1'b0;
    xfer        = 1'b0;
    eff_type    = pkt_type_q;
    beat_idx    = beat_cnt_q;

    case (state_q)
      S_IDLE: begin
        in0_ready = in0_valid & ~in0_sop;
        in1_ready = in1_valid & ~in1_sop;
        stray_d   = in0_ready | in1_ready;
        if (req0 | req1) begin
          grant_d = (req0 & req1) ? rr_next_q : req1;
          state_d = S_PASS;
        end
      end
      S_PASS: begin
        out_valid = sel_valid;
        if (grant_q) in1_ready = out_ready;
        else         in0_ready = out_ready;
        xfer = sel_valid & out_ready;
        if (xfer) begin
          if (sel_sop) begin
            eff_type   = sel_data[3:0];
            beat_idx   = 3'd0;
            pkt_type_d = sel_data[3:0];
            beat_cnt_d = 3'd1;
            in_pkt_d   = 1'b1;
            if (in_pkt_q && pkt_type_q == 4'hF) ctrl_err_d = 1'b1;
          end else begin
            beat_cnt_d = (beat_cnt_q == 3'd7) ? 3'd7 : beat_cnt_q + 3'd1;
            if (pkt_type_q == 4'hF) begin
              case (beat_cnt_q)
                3'd1: begin sh_width_d[15:12]  = sel_data[3:0]; sh_width_d[11:8]  = sel_data[11:8]; end
                3'd2: begin sh_width_d[7:4]    = sel_data[3:0]; sh_width_d[3:0]   = sel_data[11:8]; end
                3'd3: begin sh_height_d[15:12] = sel_data[3:0]; sh_height_d[11:8] = sel_data[11:8]; end
                3'd4: begin sh_height_d[7:4]   = sel_data[3:0]; sh_height_d[3:0]  = sel_data[11:8]; end
                default: ;
              endcase
            end
          end
          if (sel_eop) begin
            in_pkt_d = 1'b0;
            if (eff_type == 4'hF) begin
              // interlace nibble arrives on the eop beat itself, so take it straight from data
              if (beat_idx == 3'd5) begin
                cur_width_d  = sh_width_q;
                cur_height_d = sh_height_q;
                cur_ilace_d  = sel_data[3:0];
                upd_d        = 1'b1;
              end else begin
                ctrl_err_d = 1'b1;
              end
            end else if (eff_type == 4'h0) begin
              state_d   = S_IDLE;
              rr_next_d = ~grant_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // async reset forces IDLE, but stray drain must not show ready while reset is held
    if (reset) begin
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= FIRST_PRIORITY;
      rr_next_q    <= FIRST_PRIORITY;
      beat_cnt_q   <= 3'd0;
      pkt_type_q   <= 4'd0;
      in_pkt_q     <= 1'b0;
      sh_width_q   <= 16'd0;
      sh_height_q  <= 16'd0;
      cur_width_q  <= 16'd0;
      cur_height_q <= 16'd0;
      cur_ilace_q  <= 4'd0;
      upd_q        <= 1'b0;
      stray_q      <= 1'b0;
      ctrl_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_next_q    <= rr_next_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_type_q   <= pkt_type_d;
      in_pkt_q     <= in_pkt_d;
      sh_width_q   <= sh_width_d;
      sh_height_q  <= sh_height_d;
      cur_width_q  <= cur_width_d;
      cur_height_q <= cur_height_d;
      cur_ilace_q  <= cur_ilace_d;
      upd_q        <= upd_d;
      stray_q      <= stray_d;
      ctrl_err_q   <= ctrl_err_d;
    end
  end

  assign out_data      = sel_data;
  assign out_sop       = sel_sop;
  assign out_eop       = sel_eop;
  assign grant         = grant_q;
  assign busy          = (state_q == S_PASS);
  assign cur_width     = cur_width_q;
  assign cur_height    = cur_height_q;
  assign cur_interlace = cur_ilace_q;
  assign ctrl_update   = upd_q;
  assign err_stray     = stray_q;
  assign err_ctrl      = ctrl_err_q;

endmodule

// File: tb/tb_vip_field_arbiter_16b.sv
// Directed bench for vip_field_arbiter_16b: per-scenario tasks with inline checks
// against hand-computed frames, control decode values and grant order.
module tb_vip_field_arbiter_16b;

  logic        clock = 1'b0, reset = 1'b1;
  logic [15:0] in0_data = '0, in1_data = '0;
  logic        in0_valid = 1'b0, in0_sop = 1'b0, in0_eop = 1'b0;
  logic        in1_valid = 1'b0, in1_sop = 1'b0, in1_eop = 1'b0;
  logic        out_ready = 1'b1;
  logic        in0_ready, in1_ready, out_valid, out_sop, out_eop, grant, busy;
  logic [15:0] out_data, cur_width, cur_height;
  logic [3:0]  cur_interlace;
  logic        ctrl_update, err_stray, err_ctrl;

  vip_field_arbiter_16b #(.DATA_W(16), .FIRST_PRIORITY(1'b0)) dut (
    .clock(clock), .reset(reset),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_sop(in0_sop), .in0_eop(in0_eop),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_sop(in1_sop), .in1_eop(in1_eop),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .grant(grant), .busy(busy), .cur_width(cur_width), .cur_height(cur_height),
    .cur_interlace(cur_interlace), .ctrl_update(ctrl_update), .err_stray(err_stray), .err_ctrl(err_ctrl)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        sop;
    logic        eop;
    logic [15:0] data;
    logic        g;
  } beat_t;

  beat_t got_q[$];
  beat_t mb;
  int    cyc = 0;
  int    n_assert = 0, n_fail = 0;
  int    upd_cnt = 0, stray_cnt = 0, cerr_cnt = 0, viol_cnt = 0;
  bit    abort_tx = 1'b0, rand_en = 1'b0;

  // control packet encoding width 0x02D0, height 0x0120, interlace B
  localparam logic [15:0] CTRL_W [6] = '{16'h000F, 16'h0200, 16'h000D, 16'h0100, 16'h0002, 16'h000B};

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) if (rand_en) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      mb.cyc = cyc; mb.sop = out_sop; mb.eop = out_eop; mb.data = out_data; mb.g = grant;
      got_q.push_back(mb);
    end
    if (ctrl_update) upd_cnt++;
    if (err_stray)   stray_cnt++;
    if (err_ctrl)    cerr_cnt++;
    if (busy && !reset) begin
      if (grant ? (in0_ready !== 1'b0 || in1_ready !== out_ready)
                : (in1_ready !== 1'b0 || in0_ready !== out_ready)) viol_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] vid_word(int src, int fid, int i);
    return {src[0], fid[2:0], i[11:0]};
  endfunction

  // {sop, eop, data} of beat idx of a frame
  function automatic logic [17:0] exp_beat(int src, int fid, int cmode, int nvid, int idx);
    int nc;
    nc = (cmode == 1) ? 6 : ((cmode == 2) ? 4 : 0);
    if (idx < nc) return {idx == 0, idx == nc - 1, CTRL_W[idx]};
    return {idx == nc, idx == nc + nvid - 1, vid_word(src, fid, idx - nc)};
  endfunction

  task automatic drive_beat(input int src, input logic [15:0] d, input logic s, input logic e);
    bit acc;
    if (src == 0) begin in0_data = d; in0_sop = s; in0_eop = e; in0_valid = 1'b1; end
    else          begin in1_data = d; in1_sop = s; in1_eop = e; in1_valid = 1'b1; end
    acc = 1'b0;
    for (int k = 0; k < 5000 && !acc && !abort_tx; k++) begin
      @(negedge clock);
      acc = (src == 0) ? in0_ready : in1_ready;
      @(posedge clock); #1;
    end
    if (!acc && !abort_tx) begin
      n_assert++; n_fail++;
      $display("FAIL handshake_timeout src=%0d data=%h not accepted", src, d);
    end
  endtask

  task automatic send_frame(input int src, input int fid, input int cmode, input int nvid);
    int nc;
    nc = (cmode == 1) ? 6 : ((cmode == 2) ? 4 : 0);
    for (int i = 0; i < nc && !abort_tx; i++) drive_beat(src, CTRL_W[i], i == 0, i == nc - 1);
    for (int i = 0; i < nvid && !abort_tx; i++) drive_beat(src, vid_word(src, fid, i), i == 0, i == nvid - 1);
    if (src == 0) in0_valid = 1'b0; else in1_valid = 1'b0;
  endtask

  task automatic apply_reset();
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in0_valid = 1'b1; in0_sop = 1'b0; in1_valid = 1'b1; in1_sop = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_assert++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in0_ready got=%b exp=0", in0_ready); end
    n_assert++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in1_ready got=%b exp=0", in1_ready); end
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    n_assert++; if (grant !== 1'b0) begin n_fail++; $display("FAIL rst_grant got=%b exp=0", grant); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_assert++; if ({cur_width, cur_height, cur_interlace} !== 36'd0) begin
      n_fail++; $display("FAIL rst_cur got=%h/%h/%h exp=0/0/0", cur_width, cur_height, cur_interlace); end
    n_assert++; if ({ctrl_update, err_stray, err_ctrl} !== 3'b000) begin
      n_fail++; $display("FAIL rst_pulses got=%b exp=000", {ctrl_update, err_stray, err_ctrl}); end
  endtask

  task automatic test_single_frame();
    int base, u0, e0;
    base = got_q.size(); u0 = upd_cnt; e0 = cerr_cnt;
    send_frame(0, 0, 1, 720);
    repeat (3) @(posedge clock); #1;
    n_assert++; if (got_q.size() - base !== 726) begin
      n_fail++; $display("FAIL frame_len got=%0d exp=726", got_q.size() - base); end
    for (int i = 0; i < 726; i++) begin
      n_assert++;
      if (base + i >= got_q.size()) begin n_fail++; $display("FAIL frame_beat idx=%0d got=missing exp=%h", i, exp_beat(0, 0, 1, 720, i)); end
      else if ({got_q[base+i].sop, got_q[base+i].eop, got_q[base+i].data} !== exp_beat(0, 0, 1, 720, i)) begin
        n_fail++; $display("FAIL frame_beat idx=%0d got=%h exp=%h", i,
          {got_q[base+i].sop, got_q[base+i].eop, got_q[base+i].data}, exp_beat(0, 0, 1, 720, i)); end
    end
    n_assert++; if (cur_width !== 16'h02D0) begin n_fail++; $display("FAIL cur_width got=%h exp=02d0", cur_width); end
    n_assert++; if (cur_height !== 16'h0120) begin n_fail++; $display("FAIL cur_height got=%h exp=0120", cur_height); end
    n_assert++; if (cur_interlace !== 4'hB) begin n_fail++; $display("FAIL cur_interlace got=%h exp=b", cur_interlace); end
    n_assert++; if (upd_cnt - u0 !== 1) begin n_fail++; $display("FAIL ctrl_update_count got=%0d exp=1", upd_cnt - u0); end
    n_assert++; if (cerr_cnt - e0 !== 0) begin n_fail++; $display("FAIL good_ctrl_err got=%0d exp=0", cerr_cnt - e0); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_eop got=%b exp=0", busy); end
  endtask

  task automatic test_bad_ctrl();
    int base, u0, e0;
    base = got_q.size(); u0 = upd_cnt; e0 = cerr_cnt;
    send_frame(0, 2, 2, 8);
    repeat (3) @(posedge clock); #1;
    n_assert++; if (cerr_cnt - e0 !== 1) begin n_fail++; $display("FAIL bad_ctrl_err got=%0d exp=1", cerr_cnt - e0); end
    n_assert++; if (upd_cnt - u0 !== 0) begin n_fail++; $display("FAIL bad_ctrl_update got=%0d exp=0", upd_cnt - u0); end
    n_assert++; if ({cur_width, cur_height, cur_interlace} !== {16'h02D0, 16'h0120, 4'hB}) begin
      n_fail++; $display("FAIL bad_ctrl_cur got=%h/%h/%h exp=02d0/0120/b", cur_width, cur_height, cur_interlace); end
    n_assert++; if (got_q.size() - base !== 12) begin n_fail++; $display("FAIL bad_ctrl_len got=%0d exp=12", got_q.size() - base); end
    for (int i = 0; i < 12 && base + i < got_q.size(); i++) begin
      n_assert++;
      if ({got_q[base+i].sop, got_q[base+i].eop, got_q[base+i].data} !== exp_beat(0, 2, 2, 8, i)) begin
        n_fail++; $display("FAIL bad_ctrl_beat idx=%0d got=%h exp=%h", i,
          {got_q[base+i].sop, got_q[base+i].eop, got_q[base+i].data}, exp_beat(0, 2, 2, 8, i)); end
    end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_ctrl_release got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int base, fsrc, ffid;
    apply_reset();
    base = got_q.size();
    fork
      begin send_frame(0, 0, 0, 4); send_frame(0, 1, 0, 4); end
      begin send_frame(1, 0, 0, 4); send_frame(1, 1, 0, 4); end
    join
    repeat (2) @(posedge clock); #1;
    n_assert++; if (got_q.size() - base !== 16) begin n_fail++; $display("FAIL rr_len got=%0d exp=16", got_q.size() - base); end
    for (int f = 0; f < 4; f++) begin
      fsrc = f % 2; ffid = f / 2;
      for (int i = 0; i < 4 && base + 4*f + i < got_q.size(); i++) begin
        n_assert++;
        if ({got_q[base+4*f+i].g, got_q[base+4*f+i].sop, got_q[base+4*f+i].eop, got_q[base+4*f+i].data}
            !== {fsrc[0], exp_beat(fsrc, ffid, 0, 4, i)}) begin
          n_fail++; $display("FAIL rr_beat frame=%0d idx=%0d got=%h exp=%h", f, i,
            {got_q[base+4*f+i].g, got_q[base+4*f+i].sop, got_q[base+4*f+i].eop, got_q[base+4*f+i].data},
            {fsrc[0], exp_beat(fsrc, ffid, 0, 4, i)}); end
      end
      if (f > 0 && base + 4*f < got_q.size()) begin
        n_assert++;
        if (got_q[base+4*f].cyc - got_q[base+4*f-1].cyc !== 2) begin
          n_fail++; $display("FAIL rr_gap frame=%0d got=%0d exp=2 cycles eop-to-sop", f,
            got_q[base+4*f].cyc - got_q[base+4*f-1].cyc); end
      end
    end
  endtask

  task automatic test_stray();
    int s0;
    s0 = stray_cnt;
    @(posedge clock); #1;
    in1_valid = 1'b1; in1_sop = 1'b0; in1_eop = 1'b0; in1_data = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_assert++; if (in1_ready !== 1'b1) begin n_fail++; $display("FAIL stray_ready cyc=%0d got=%b exp=1", k, in1_ready); end
      n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stray_out_valid cyc=%0d got=%b exp=0", k, out_valid); end
      @(posedge clock); #1;
    end
    in1_valid = 1'b0;
    repeat (2) @(posedge clock); #1;
    n_assert++; if (stray_cnt - s0 !== 3) begin n_fail++; $display("FAIL stray_pulses got=%0d exp=3", stray_cnt - s0); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    int base, v0;
    base = got_q.size(); v0 = viol_cnt;
    @(posedge clock); #1;
    rand_en = 1'b1;
    send_frame(1, 3, 1, 40);
    rand_en = 1'b0;
    @(posedge clock); #2 out_ready = 1'b1;
    @(posedge clock); #1;
    n_assert++; if (got_q.size() - base !== 46) begin n_fail++; $display("FAIL bp_len got=%0d exp=46", got_q.size() - base); end
    for (int i = 0; i < 46 && base + i < got_q.size(); i++) begin
      n_assert++;
      if ({got_q[base+i].sop, got_q[base+i].eop, got_q[base+i].data} !== exp_beat(1, 3, 1, 40, i)) begin
        n_fail++; $display("FAIL bp_beat idx=%0d got=%h exp=%h", i,
          {got_q[base+i].sop, got_q[base+i].eop, got_q[base+i].data}, exp_beat(1, 3, 1, 40, i)); end
    end
    n_assert++; if (viol_cnt - v0 !== 0) begin n_fail++; $display("FAIL bp_ready_rule got=%0d violations exp=0", viol_cnt - v0); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = got_q.size();
    abort_tx = 1'b0;
    fork send_frame(0, 4, 1, 300); join_none
    for (int k = 0; k < 3000 && got_q.size() < base + 106; k++) @(posedge clock);
    #1 abort_tx = 1'b1; reset = 1'b1;
    #1;
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    n_assert++; if ({in0_ready, in1_ready} !== 2'b00) begin n_fail++; $display("FAIL midrst_ready got=%b exp=00", {in0_ready, in1_ready}); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got=%b exp=0", busy); end
    repeat (2) @(posedge clock); #1;
    reset = 1'b0; abort_tx = 1'b0;
    @(posedge clock); #1;
    n_assert++; if ({cur_width, cur_height, cur_interlace} !== 36'd0) begin
      n_fail++; $display("FAIL midrst_cur got=%h/%h/%h exp=0/0/0", cur_width, cur_height, cur_interlace); end
    n_assert++; if ({grant, busy} !== 2'b00) begin n_fail++; $display("FAIL midrst_grant got=%b exp=00", {grant, busy}); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bad_ctrl();
    test_round_robin();
    test_stray();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
